// File: rtl/fma_dot_pkg.sv
// Shared definitions for the sequential dot-product initiator that drives fpfma.
// Format constants mirror the existing fpfma parameter set.
package fma_dot_pkg;

   localparam int WIDTH     = 32;
   localparam int EXP_WIDTH = 8;
   localparam int SIG_WIDTH = 23;

   // Canonical quiet NaN produced by fpfma for invalid operations.
   localparam logic [WIDTH-1:0] code_NaN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } fma_dot_state_t;

endpackage

// File: rtl/fma_dot_seq.sv
// Streams (a, b) pairs through an external combinational fpfma, accumulating
// a*b + acc one beat per cycle and returning the final sum over valid/ready.
module fma_dot_seq #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_last,
   input  logic [WIDTH-1:0]     acc_init,
   input  logic [1:0]           rnd,
   output logic [WIDTH-1:0]     fma_a,
   output logic [WIDTH-1:0]     fma_b,
   output logic [WIDTH-1:0]     fma_c,
   output logic [1:0]           fma_rnd,
   input  logic [WIDTH-1:0]     fma_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_result,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_nan
);
   import fma_dot_pkg::*;

   localparam logic [WIDTH-1:0] NAN_CODE = WIDTH'(code_NaN);

   fma_dot_state_t       state, state_nxt;
   logic [WIDTH-1:0]     op_a, op_b, acc;
   logic                 op_vld, op_last, nan_q;
   logic [1:0]           rnd_q;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 accept, first_beat;

   assign accept     = in_valid & in_ready;
   assign first_beat = accept & (state == IDLE);

   // in_ready and out_valid depend on state only, never on in_valid/out_ready.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept) state_nxt = in_last ? FLUSH : RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            if (accept && in_last) state_nxt = FLUSH;
         end
         FLUSH: begin
            if (op_vld && op_last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand stage: a new accept overwrites the beat whose result is captured
   // on the same edge, so the stream runs at one beat per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a    <= '0;
         op_b    <= '0;
         op_vld  <= 1'b0;
         op_last <= 1'b0;
      end else if (accept) begin
         op_a    <= in_a;
         op_b    <= in_b;
         op_vld  <= 1'b1;
         op_last <= in_last;
      end else begin
         op_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         rnd_q <= '0;
         cnt   <= '0;
         nan_q <= 1'b0;
      end else if (first_beat) begin
         acc   <= acc_init;
         rnd_q <= rnd;
         cnt   <= '0;
         nan_q <= 1'b0;
      end else if (op_vld) begin
         acc   <= fma_result;
         if (cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
         nan_q <= nan_q | (fma_result == NAN_CODE);
      end
   end

   assign fma_a      = op_a;
   assign fma_b      = op_b;
   assign fma_c      = acc;
   assign fma_rnd    = rnd_q;
   assign out_result = acc;
   assign out_count  = cnt;
   assign out_nan    = nan_q;

endmodule

// File: tb/tb_fma_dot_seq.sv
// Bench for fma_dot_seq: a real-arithmetic fpfma stand-in closes the loop and
// expected dot products are summed directly from the beat lists.
module tb_fma_dot_seq;
   localparam int W  = 32;
   localparam int CW = 4;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid, in_ready, in_last, out_valid, out_ready, out_nan;
   logic [W-1:0]  in_a, in_b, acc_init, fma_a, fma_b, fma_c, fma_result, out_result;
   logic [1:0]    rnd, fma_rnd;
   logic [CW-1:0] out_count;

   int errors = 0;
   int checks = 0;
   logic [31:0] beat_a [32];
   logic [31:0] beat_b [32];

   always #5 clk = ~clk;

   fma_dot_seq #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .acc_init(acc_init), .rnd(rnd),
      .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_rnd(fma_rnd),
      .fma_result(fma_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_count(out_count), .out_nan(out_nan)
   );

   function automatic bit is_nan(logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   function automatic real sp2r(logic [31:0] x);
      real v;
      int  e;
      e = int'(x[30:23]);
      if (e == 0) return 0.0;
      v = 1.0 + real'(x[22:0]) / 8388608.0;
      e = e - 127;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return x[31] ? -v : v;
   endfunction

   function automatic logic [31:0] r2sp(real r);
      logic s;
      real  v;
      int   e;
      if (r == 0.0) return 32'd0;
      s = (r < 0.0);
      v = s ? -r : r;
      e = 0;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0)  begin v = v * 2.0; e--; end
      return {s, 8'(e + 127), 23'($rtoi((v - 1.0) * 8388608.0))};
   endfunction

   // Stand-in for the external fpfma; exact for the small integers used here.
   function automatic logic [31:0] fpfma_ref(logic [31:0] a, logic [31:0] b, logic [31:0] c);
      if (is_nan(a) || is_nan(b) || is_nan(c)) return QNAN;
      return r2sp(sp2r(a) * sp2r(b) + sp2r(c));
   endfunction

   always_comb fma_result = fpfma_ref(fma_a, fma_b, fma_c);

   // Drives one vector from beat_a/beat_b, holds garbage on the input while
   // the block is busy, and completes the output handshake after `hold` cycles.
   task automatic run_vector(input logic [31:0] init, input logic [1:0] r, input int n,
                             input int gap_pct, input int hold,
                             output logic [31:0] res, output logic [CW-1:0] cnt,
                             output logic nan, output int lat, output logic [1:0] rnd_seen,
                             output bit bad_hold, output bit to);
      int i, guard;
      i = 0; guard = 0; to = 0; bad_hold = 0; lat = 0;
      res = '0; cnt = '0; nan = 1'b0; rnd_seen = '0;
      while (i < n && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_a     = beat_a[i];
            in_b     = beat_b[i];
            in_last  = (i == n - 1);
            acc_init = (i == 0) ? init : $urandom;
            rnd      = (i == 0) ? r : ~r;
            if (in_ready) i++;
         end
      end
      if (i < n) begin
         to = 1; in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      lat = 1;
      rnd_seen = fma_rnd;
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_last = 1'b1; acc_init = $urandom;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      if (!out_valid) begin
         to = 1; in_valid = 1'b0;
         return;
      end
      res = out_result; cnt = out_count; nan = out_nan;
      for (int k = 0; k < hold; k++) begin
         if (in_ready || !out_valid || out_result !== res || out_count !== cnt || out_nan !== nan)
            bad_hold = 1;
         @(negedge clk);
      end
      if (in_ready || !out_valid || out_result !== res) bad_hold = 1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (out_valid) bad_hold = 1;
   endtask

   logic [31:0]   g_res;
   logic [CW-1:0] g_cnt;
   logic          g_nan;
   int            g_lat;
   logic [1:0]    g_rnd;
   bit            g_bad, g_to;

   task automatic load_spec_two_beat();
      beat_a[0] = 32'h4000_0000; beat_b[0] = 32'h4040_0000;
      beat_a[1] = 32'h3F80_0000; beat_b[1] = 32'h4000_0000;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
      acc_init = '0; rnd = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_result !== '0 || out_count !== '0 || out_nan !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got valid=%b res=%h cnt=%0d nan=%b want 0", out_valid, out_result, out_count, out_nan);
      end
      checks++;
      if ({fma_a, fma_b, fma_c, fma_rnd} !== '0) begin
         errors++;
         $display("FAIL reset_fma got a=%h b=%h c=%h rnd=%b want 0", fma_a, fma_b, fma_c, fma_rnd);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_two_beat();
      load_spec_two_beat();
      run_vector(32'h3F80_0000, 2'b10, 2, 0, 0, g_res, g_cnt, g_nan, g_lat, g_rnd, g_bad, g_to);
      checks++;
      if (g_to || g_res !== 32'h4110_0000 || g_cnt !== 4'd2 || g_nan !== 1'b0) begin
         errors++;
         $display("FAIL two_beat got to=%b res=%h cnt=%0d nan=%b want 41100000/2/0", g_to, g_res, g_cnt, g_nan);
      end
      checks++;
      if (g_lat != 2) begin
         errors++;
         $display("FAIL two_beat_latency got %0d want 2", g_lat);
      end
      checks++;
      if (g_rnd !== 2'b10) begin
         errors++;
         $display("FAIL two_beat_rnd_held got %b want 10", g_rnd);
      end
      checks++;
      if (g_bad) begin
         errors++;
         $display("FAIL two_beat_handshake got unstable/late-drop want clean");
      end
   endtask

   task automatic test_single_beat();
      beat_a[0] = 32'h4040_0000; beat_b[0] = 32'h4040_0000;
      run_vector(32'h3F80_0000, 2'b01, 1, 0, 0, g_res, g_cnt, g_nan, g_lat, g_rnd, g_bad, g_to);
      checks++;
      if (g_to || g_res !== 32'h4120_0000 || g_cnt !== 4'd1 || g_lat != 2 || g_rnd !== 2'b01) begin
         errors++;
         $display("FAIL single_beat got to=%b res=%h cnt=%0d lat=%0d rnd=%b want 41200000/1/2/01",
                  g_to, g_res, g_cnt, g_lat, g_rnd);
      end
   endtask

   task automatic test_bubbles_backpressure();
      load_spec_two_beat();
      run_vector(32'h3F80_0000, 2'b10, 2, 50, 5, g_res, g_cnt, g_nan, g_lat, g_rnd, g_bad, g_to);
      checks++;
      if (g_to || g_res !== 32'h4110_0000 || g_cnt !== 4'd2 || g_nan !== 1'b0) begin
         errors++;
         $display("FAIL bubbles got to=%b res=%h cnt=%0d nan=%b want 41100000/2/0", g_to, g_res, g_cnt, g_nan);
      end
      checks++;
      if (g_bad) begin
         errors++;
         $display("FAIL backpressure_stable got outputs changing or in_ready high in DONE want stable");
      end
   endtask

   task automatic test_nan();
      beat_a[0] = 32'h3F80_0000; beat_b[0] = 32'h3F80_0000;
      beat_a[1] = QNAN;          beat_b[1] = 32'h3F80_0000;
      beat_a[2] = 32'h3F80_0000; beat_b[2] = 32'h3F80_0000;
      run_vector(32'h0, 2'b00, 3, 20, 1, g_res, g_cnt, g_nan, g_lat, g_rnd, g_bad, g_to);
      checks++;
      if (g_to || g_nan !== 1'b1 || g_res !== QNAN || g_cnt !== 4'd3) begin
         errors++;
         $display("FAIL nan got to=%b nan=%b res=%h cnt=%0d want 1/7fc00000/3", g_to, g_nan, g_res, g_cnt);
      end
   endtask

   task automatic test_back_to_back();
      beat_a[0] = QNAN; beat_b[0] = 32'h3F80_0000;
      beat_a[1] = 32'h4000_0000; beat_b[1] = 32'h4000_0000;
      beat_a[2] = 32'h4000_0000; beat_b[2] = 32'h4000_0000;
      run_vector(32'h0, 2'b11, 3, 0, 0, g_res, g_cnt, g_nan, g_lat, g_rnd, g_bad, g_to);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready_after_handshake got %b want 1", in_ready);
      end
      beat_a[0] = 32'h3F80_0000; beat_b[0] = 32'h3F80_0000;
      run_vector(32'h4000_0000, 2'b00, 1, 0, 0, g_res, g_cnt, g_nan, g_lat, g_rnd, g_bad, g_to);
      checks++;
      if (g_to || g_res !== 32'h4040_0000 || g_cnt !== 4'd1 || g_nan !== 1'b0 || g_rnd !== 2'b00) begin
         errors++;
         $display("FAIL back_to_back got to=%b res=%h cnt=%0d nan=%b rnd=%b want 40400000/1/0/00",
                  g_to, g_res, g_cnt, g_nan, g_rnd);
      end
   endtask

   task automatic test_reset_mid_vector();
      bit seen;
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h3F80_0000; in_last = 1'b0;
      acc_init = 32'h3F80_0000; rnd = 2'b00;
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      checks++;
      if (seen || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid got out_valid_seen=%b in_ready=%b want 0/1", seen, in_ready);
      end
      load_spec_two_beat();
      run_vector(32'h3F80_0000, 2'b10, 2, 0, 0, g_res, g_cnt, g_nan, g_lat, g_rnd, g_bad, g_to);
      checks++;
      if (g_to || g_res !== 32'h4110_0000 || g_cnt !== 4'd2) begin
         errors++;
         $display("FAIL reset_mid_fresh got to=%b res=%h cnt=%0d want 41100000/2", g_to, g_res, g_cnt);
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 20; k++) begin
         beat_a[k] = 32'h3F80_0000; beat_b[k] = 32'h3F80_0000;
      end
      run_vector(32'h0, 2'b00, 20, 0, 0, g_res, g_cnt, g_nan, g_lat, g_rnd, g_bad, g_to);
      checks++;
      if (g_to || g_res !== 32'h41A0_0000 || g_cnt !== 4'hF) begin
         errors++;
         $display("FAIL saturation got to=%b res=%h cnt=%0d want 41a00000/15", g_to, g_res, g_cnt);
      end
   endtask

   task automatic test_random();
      int          n, init_i, av, bv, cnt_exp;
      real         sum;
      bit          nan_exp;
      logic [31:0] res_exp;
      for (int v = 0; v < 10; v++) begin
         n = int'($urandom_range(6, 1));
         init_i = int'($urandom_range(7));
         sum = real'(init_i);
         nan_exp = 0;
         for (int k = 0; k < n; k++) begin
            av = int'($urandom_range(7));
            bv = int'($urandom_range(7));
            beat_a[k] = ($urandom_range(9) == 0) ? QNAN : r2sp(real'(av));
            beat_b[k] = r2sp(real'(bv));
            if (beat_a[k] == QNAN) nan_exp = 1;
            sum = sum + real'(av) * real'(bv);
         end
         cnt_exp = (n > 15) ? 15 : n;
         res_exp = nan_exp ? QNAN : r2sp(sum);
         run_vector(r2sp(real'(init_i)), 2'($urandom_range(3)), n, 30, int'($urandom_range(3)),
                    g_res, g_cnt, g_nan, g_lat, g_rnd, g_bad, g_to);
         checks++;
         if (g_to || g_res !== res_exp || g_cnt !== CW'(cnt_exp) || g_nan !== nan_exp
             || g_lat != 2 || g_bad) begin
            errors++;
            $display("FAIL random[%0d] got to=%b res=%h cnt=%0d nan=%b lat=%0d bad=%b want res=%h cnt=%0d nan=%b lat=2",
                     v, g_to, g_res, g_cnt, g_nan, g_lat, g_bad, res_exp, cnt_exp, nan_exp);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_two_beat();
      test_single_beat();
      test_bubbles_backpressure();
      test_nan();
      test_back_to_back();
      test_reset_mid_vector();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fma_dot_seq.md
# fma_dot_seq

Sequential dot-product initiator for the `fpfma` datapath. It accepts a stream of (a, b) operand pairs over a valid/ready handshake and drives the combinational `fpfma` with `A=a`, `B=b`, `C=running accumulator`. It captures each `fpfma` result back into the accumulator and emits the final accumulated value over a valid/ready output handshake. It sits between an operand-fetch front end and the `fpfma` instance, owning all of the state that `fpfma` lacks.

## Interface
- `WIDTH`, 32, floating-point word width (shared with `fpfma`)
- `CNT_WIDTH`, 16, beat-counter width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: operand beat valid
- `in_ready` out 1: block accepts beat
- `in_a` in WIDTH: multiplicand
- `in_b` in WIDTH: multiplier
- `in_last` in 1: final beat of vector
- `acc_init` in WIDTH: initial C; sampled on first beat of a vector only
- `rnd` in 2: rounding mode; sampled on first beat, held for whole vector
- `fma_a` out WIDTH: drives `fpfma` A
- `fma_b` out WIDTH: drives `fpfma` B
- `fma_c` out WIDTH: drives `fpfma` C
- `fma_rnd` out 2: drives `fpfma` rnd
- `fma_result` in WIDTH: `fpfma` result, combinational from `fma_*`
- `out_valid` out 1: dot result valid
- `out_ready` in 1: consumer accepts result
- `out_result` out WIDTH: final accumulator
- `out_count` out CNT_WIDTH: beats in vector, saturating
- `out_nan` out 1: any intermediate result equalled `code_NaN`

## Operation
- **Registers:** op_a, op_b, op_vld, op_last, acc, rnd_q, cnt, nan_q, and state.
- **Outputs from registers:** `fma_a=op_a`, `fma_b=op_b`, `fma_c=acc`, `fma_rnd=rnd_q`.
- **States:**
  - IDLE: waiting for first beat; `in_ready=1`.
  - RUN: streaming; `in_ready=1`.
  - FLUSH: last beat is in the op registers; `in_ready=0`.
  - DONE: `out_valid=1`; `in_ready=0`.
- **Beat accept (`in_valid & in_ready`):** op_a/op_b/op_last load; op_vld=1.
  - In IDLE, the accept also loads `acc<=acc_init` and `rnd_q<=rnd`, clears cnt and nan_q, and goes to RUN. If `in_last` is set, it goes to FLUSH instead.
  - In RUN, an accept with `in_last` goes to FLUSH.
- **Accumulate:** on every edge where op_vld=1:
  - `acc<=fma_result`;
  - cnt increments, saturating at all-ones;
  - `nan_q|=(fma_result==code_NaN)`.
  - With no new accept on that edge, op_vld clears.
- **Throughput:** one beat per cycle. The edge that captures beat k's result also loads beat k+1, so `fma_c` always reflects the previous beat.
- **FLUSH → DONE:** on the edge that captures the last result.
- **DONE:** holds `out_result=acc`, `out_count=cnt`, `out_nan=nan_q`. On `out_valid & out_ready`, goes to IDLE.
- **RUN with no valid input:** the block waits; bubbles are allowed, and op_vld=0 leaves acc unchanged.
- **Single-beat vector:** IDLE → FLUSH → DONE; result = a·b+acc_init.
- **`in_valid` while in FLUSH/DONE:** ignored (`in_ready=0`). The upstream source must hold the beat.
- **Counter saturation:** cnt saturates silently.
- **Special cases:** `fpfma` special-case outputs (zero/NaN/Inf) are accumulated as-is; there is no special-case handling here.
- **Reset mid-vector:** the vector is abandoned, no output is produced, and the state returns to IDLE.

## Timing
- **Reset values:** all outputs and registers are 0 and state is IDLE. `in_ready=1` once `rst_n` deasserts; `out_valid=0`.
- **Latency:** last beat accepted at edge k → result captured at edge k+1 → `out_valid` high in the cycle following edge k+1.
- **`out_valid` rules:** once asserted, `out_valid` and its data stay stable until the handshake. They drop on the edge after `out_ready` is sampled high.
- **`in_ready`:** a pure function of state, with no combinational path from `in_valid` or `out_ready`.
- **Next vector:** the earliest next-vector accept is the cycle after the output handshake.
- **Timing path:** `fma_result` is the only combinational input into state. The `fpfma` critical path lands op registers → acc within one cycle.

## Structure
- **Shared package:** state encoding `fma_dot_state_t` {IDLE, RUN, FLUSH, DONE}, plus `code_NaN`, `WIDTH`, `EXP_WIDTH`, `SIG_WIDTH` from the existing `parameters.v` set.
- **Sub-modules:** no sub-module inside this block. `fpfma` is instantiated alongside it by the parent, not inside it, so that pipelined FMA variants can be substituted later.

## Test plan
- **Two-beat vector:** init 1.0 (0x3F800000), rnd=10, beats (2.0, 3.0), (1.0, 2.0 last) → `out_result=0x41100000` (9.0), `out_count=2`, `out_nan=0`, `out_valid` two cycles after the last accept.
- **Single beat:** init 1.0, (3.0, 3.0 last) → 0x41200000 (10.0), count 1.
- **Bubbles and back-pressure:** `in_valid` toggling 1-0-1, `out_ready` held low 5 cycles → same result as the gap-free run; `out_*` stable throughout; `in_ready=0` during DONE.
- **NaN propagation:** a beat with `in_a=0x7FC00000` mid-vector → `out_nan=1`.
- **Back-to-back vectors:** second vector (init 0x40000000, (1.0, 1.0 last)) accepted the cycle after the first handshake → 0x40400000; first vector's count/nan are not carried over.
- **Reset mid-vector:** `rst_n` pulsed low after beat 1 of 3 → `out_valid` never asserts; a fresh vector afterwards gives the correct result.
